// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART transmit path.
//   state_t       : arbiter FSM encoding (IDLE, START, WAIT)
//   OVERSAMPLING,
//   BAUD_RATE,
//   CLOCK_RATE    : defaults shared with the baud tick generator
//   DEF_DATA_W    : default byte width per frame
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam int OVERSAMPLING = 16;
    localparam int BAUD_RATE    = 9600;
    localparam int CLOCK_RATE   = 100_000_000;
    localparam int DEF_DATA_W   = 8;

    // System clocks per oversampling tick, for the tick generator.
    localparam int TICK_DIV = CLOCK_RATE / (BAUD_RATE * OVERSAMPLING);

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if -- bundle between byte producers, the arbiter and the
// UART transmitter.
//   req_valid/req_data/req_ready : per-requester byte handshake
//   tx_start/tx_data             : load command towards the transmitter
//   tx_busy/tx_done              : transmitter status
//   grant_id/active              : current owner of the transmitter
// Modports: slave = arbiter side, master = producers + transmitter side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      tx_start;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_busy;
    logic                      tx_done;
    logic [ID_W-1:0]           grant_id;
    logic                      active;

    modport slave (
        input  req_valid, req_data, tx_busy, tx_done,
        output req_ready, tx_start, tx_data, grant_id, active
    );

    modport master (
        output req_valid, req_data, tx_busy, tx_done,
        input  req_ready, tx_start, tx_data, grant_id, active
    );

endinterface

// File: rtl/uart_rr_picker.sv
// uart_rr_picker -- combinational round-robin winner search.
//   req        : request vector, bit i = requester i
//   last_grant : most recently granted index; search starts one above it
//   winner     : first set bit at last_grant+1, last_grant+2, ... mod NUM_REQ
//   any_valid  : at least one request bit set
module uart_rr_picker #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [ID_W-1:0]    winner,
    output logic               any_valid
);

    always_comb begin
        int              idx;
        logic [ID_W-1:0] sel;
        idx       = 0;
        sel       = '0;
        winner    = '0;
        any_valid = 1'b0;
        // Walk from the farthest candidate to the nearest so the nearest
        // set bit is the last write. last_grant+k never exceeds 2*NUM_REQ-1,
        // so a single subtract is a full modulo and idx stays < NUM_REQ
        // even when NUM_REQ is not a power of two.
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = int'(last_grant) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            sel = ID_W'(idx);
            if (req[sel]) begin
                winner    = sel;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter -- round-robin scheduler sharing one UART transmitter
// between NUM_REQ byte sources.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : uart_tx_arbiter_if.slave (request handshake, tx command,
//             tx status, grant_id/active)
// Build option: UART_TX_ARB_PRIORITY_EN makes requester 0 strict high
// priority; requesters 1..NUM_REQ-1 round-robin among themselves.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic               clk,
    input  logic               reset_n,
    uart_tx_arbiter_if.slave   bus
);

    localparam int              ID_W    = $clog2(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    state_t                           state, state_nx;
    logic [ID_W-1:0]                  last_grant;
    logic [ID_W-1:0]                  winner;
    logic                             any_valid;
    logic                             grant_go;
    logic [NUM_REQ-1:0][DATA_W-1:0]   req_bytes;

    logic [NUM_REQ-1:0]               ready_q;
    logic                             start_q;
    logic [DATA_W-1:0]                data_q;
    logic [ID_W-1:0]                  id_q;
    logic                             active_q;

    assign req_bytes = bus.req_data;

`ifdef UART_TX_ARB_PRIORITY_EN
    logic [ID_W-1:0] rr_winner;
    logic            rr_any;

    // Requester 0 is masked out of the rotation; it wins outright when valid.
    uart_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req        ({bus.req_valid[NUM_REQ-1:1], 1'b0}),
        .last_grant (last_grant),
        .winner     (rr_winner),
        .any_valid  (rr_any)
    );

    assign winner    = bus.req_valid[0] ? '0 : rr_winner;
    assign any_valid = bus.req_valid[0] | rr_any;
`else
    uart_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .winner     (winner),
        .any_valid  (any_valid)
    );
`endif

    assign grant_go = (state == IDLE) && !bus.tx_busy && any_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // tx_done is only honoured in WAIT; one seen in START belongs to a
    // previous frame.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (grant_go) state_nx = START;
            START:   state_nx = WAIT;
            WAIT:    if (bus.tx_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= LAST_ID;
            ready_q    <= '0;
            start_q    <= 1'b0;
            data_q     <= '0;
            id_q       <= '0;
            active_q   <= 1'b0;
        end else begin
            ready_q <= '0;
            // Registered off START so the pulse lands one cycle after accept.
            start_q <= (state == START);
            if (grant_go) begin
                ready_q  <= NUM_REQ'(1) << winner;
                data_q   <= req_bytes[winner];
                id_q     <= winner;
                active_q <= 1'b1;
`ifdef UART_TX_ARB_PRIORITY_EN
                // A requester-0 grant leaves the rotation pointer alone.
                if (!bus.req_valid[0]) last_grant <= winner;
`else
                last_grant <= winner;
`endif
            end else if (state == WAIT && bus.tx_done) begin
                active_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.tx_start  = start_q;
    assign bus.tx_data   = data_q;
    assign bus.grant_id  = id_q;
    assign bus.active    = active_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter -- self-checking bench for uart_tx_arbiter.
// Plays the producers and the transmitter; a transaction-level model holds
// only the last granted index and derives each expected winner from the
// request vector present at the accept edge.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int ID_W    = $clog2(NUM_REQ);

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [NUM_REQ-1:0][DATA_W-1:0] data_arr;
    assign bus.req_data = data_arr;

    int n_chk = 0;
    int n_bad = 0;
    int last_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected winner: nearest valid index after last_m, modulo NUM_REQ.
    function automatic int pick(input logic [NUM_REQ-1:0] v);
`ifdef UART_TX_ARB_PRIORITY_EN
        if (v[0]) return 0;
`endif
        for (int k = 1; k <= NUM_REQ; k++) begin
            int i;
            i = (last_m + k) % NUM_REQ;
`ifdef UART_TX_ARB_PRIORITY_EN
            if (i == 0) continue;
`endif
            if (v[i]) return i;
        end
        return 0;
    endfunction

    // One complete frame starting from IDLE with the transmitter idle.
    task automatic do_frame(input logic [NUM_REQ-1:0] v, input bit keep,
                            input int gap, output int got_id);
        int                w;
        logic [DATA_W-1:0] exp_d;
        w     = pick(v);
        exp_d = data_arr[w[ID_W-1:0]];
        bus.req_valid = v;
        tick;
        got_id = int'(bus.grant_id);
        chk("accept_ready", 32'(bus.req_ready), 32'(1) << w);
        chk("accept_id",    32'(bus.grant_id),  32'(w));
        chk("accept_active", 32'(bus.active),   32'(1));
        chk("accept_nostart", 32'(bus.tx_start), 32'(0));
`ifdef UART_TX_ARB_PRIORITY_EN
        if (w != 0) last_m = w;
`else
        last_m = w;
`endif
        // Producer may present a fresh byte right after its accept.
        data_arr[w[ID_W-1:0]] = DATA_W'($urandom);
        if (!keep) bus.req_valid[w[ID_W-1:0]] = 1'b0;
        tick;
        chk("start_pulse", 32'(bus.tx_start), 32'(1));
        chk("start_data",  32'(bus.tx_data),  32'(exp_d));
        chk("start_ready", 32'(bus.req_ready), 32'(0));
        bus.tx_busy = 1'b1;
        for (int c = 0; c < gap; c++) begin
            tick;
            chk("wait_start",  32'(bus.tx_start),  32'(0));
            chk("wait_ready",  32'(bus.req_ready), 32'(0));
            chk("wait_active", 32'(bus.active),    32'(1));
            chk("wait_data",   32'(bus.tx_data),   32'(exp_d));
            chk("wait_id",     32'(bus.grant_id),  32'(w));
        end
        bus.tx_done = 1'b1;
        tick;
        bus.tx_done = 1'b0;
        bus.tx_busy = 1'b0;
        chk("done_active", 32'(bus.active),    32'(0));
        chk("done_ready",  32'(bus.req_ready), 32'(0));
    endtask

    initial begin
        int g;
        bus.req_valid = '1;
        bus.tx_busy   = 1'b0;
        bus.tx_done   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) data_arr[i] = DATA_W'($urandom);
        last_m = NUM_REQ - 1;

        // Reset held with every requester valid.
        repeat (3) tick;
        chk("rst_ready",  32'(bus.req_ready), 32'(0));
        chk("rst_start",  32'(bus.tx_start),  32'(0));
        chk("rst_active", 32'(bus.active),    32'(0));
        chk("rst_id",     32'(bus.grant_id),  32'(0));
        chk("rst_data",   32'(bus.tx_data),   32'(0));
        reset_n = 1'b1;

        // Rotation with all requesters continuously valid.
        for (int k = 0; k < 6; k++) begin
            do_frame('1, 1'b1, 20, g);
`ifdef UART_TX_ARB_PRIORITY_EN
            chk("rot_order", 32'(g), 32'(0));
`else
            chk("rot_order", 32'(g), 32'(k % NUM_REQ));
`endif
        end

        // Single byte from requester 2.
        bus.req_valid = '0;
        data_arr[2]   = 8'hA5;
        do_frame(4'b0100, 1'b0, 5, g);
        chk("single_id", 32'(g), 32'(2));

        // Busy hold-off.
        bus.req_valid = 4'b0001;
        bus.tx_busy   = 1'b1;
        repeat (4) begin
            tick;
            chk("busy_ready",  32'(bus.req_ready), 32'(0));
            chk("busy_active", 32'(bus.active),    32'(0));
        end
        bus.tx_busy = 1'b0;
        do_frame(4'b0001, 1'b0, 3, g);
        chk("busy_id", 32'(g), 32'(0));

        // Randomized traffic with withdrawals and busy stalls.
        for (int n = 0; n < 40; n++) begin
            logic [NUM_REQ-1:0] v;
            v = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            if ($urandom_range(0, 3) == 0) begin
                bus.req_valid = v;
                bus.tx_busy   = 1'b1;
                repeat ($urandom_range(1, 3)) begin
                    tick;
                    chk("rnd_busy_ready", 32'(bus.req_ready), 32'(0));
                end
                bus.tx_busy = 1'b0;
            end
            do_frame(v, 1'($urandom_range(0, 1)), $urandom_range(1, 6), g);
        end

        // Reset in the middle of a frame.
        bus.req_valid = 4'b0010;
        data_arr[1]   = 8'h5A;
        last_m        = 0;
        tick;
        chk("mid_ready", 32'(bus.req_ready), 32'(4'b0010));
        tick;
        chk("mid_start", 32'(bus.tx_start), 32'(1));
        bus.tx_busy = 1'b1;
        repeat (3) tick;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_active", 32'(bus.active),    32'(0));
        chk("mid_rst_id",     32'(bus.grant_id),  32'(0));
        chk("mid_rst_data",   32'(bus.tx_data),   32'(0));
        chk("mid_rst_ready",  32'(bus.req_ready), 32'(0));
        chk("mid_rst_start",  32'(bus.tx_start),  32'(0));
        bus.tx_busy = 1'b0;
        last_m      = NUM_REQ - 1;
        tick;
        reset_n = 1'b1;
        do_frame(4'b0010, 1'b0, 4, g);
        chk("mid_regrant", 32'(g), 32'(1));

`ifdef UART_TX_ARB_PRIORITY_EN
        // Requester 0 dominates while valid, then requester 1 follows.
        for (int k = 0; k < 3; k++) begin
            do_frame(4'b0011, 1'b1, 2, g);
            chk("pri_zero", 32'(g), 32'(0));
        end
        do_frame(4'b0010, 1'b0, 2, g);
        chk("pri_one", 32'(g), 32'(1));
`endif

        bus.req_valid = '0;
        repeat (2) tick;
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
